// File: rtl/fb_pkg.sv
// Shared types and helpers for the frame buffer controller and its RAM.
package fb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } fb_state_t;

  localparam int INIT_ZERO    = 0;
  localparam int INIT_CHECKER = 1;

  // Linear pixel address {y, x}; callers truncate the result to their own AW.
  function automatic logic [31:0] fb_addr(input logic [31:0] x,
                                          input logic [31:0] y,
                                          input int          x_bits);
    return (y << x_bits) | x;
  endfunction

endpackage

// File: rtl/fb_ram.sv
// Pixel store: one write port and one registered read-first read port, with
// contents pre-loaded from the power-up pattern.
module fb_ram
  import fb_pkg::*;
#(
  parameter int AW           = 15,
  parameter int PIX_W        = 1,
  parameter int INIT_PATTERN = INIT_CHECKER,
  parameter int GRID_BIT     = 0,
  parameter int X_BITS       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [PIX_W-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [PIX_W-1:0] rdata
);

  localparam int DEPTH = 1 << AW;
  localparam int MEM_W = DEPTH * PIX_W;

  function automatic logic [MEM_W-1:0] init_image();
    logic [MEM_W-1:0] img;
    int               xb;
    int               yb;
    img = '0;
    if (INIT_PATTERN == INIT_CHECKER) begin
      for (int a = 0; a < DEPTH; a++) begin
        xb = (a >> GRID_BIT) & 1;
        yb = (a >> (X_BITS + GRID_BIT)) & 1;
        img[a*PIX_W +: PIX_W] = {PIX_W{(xb ^ yb) != 0}};
      end
    end
    return img;
  endfunction

  // NOTE: the array is loaded once at configuration and has no reset branch;
  // clearing a whole memory on reset would turn it into flops and break the
  // "reset never alters pixels" contract.
  logic [MEM_W-1:0] mem_q = init_image();
  logic [PIX_W-1:0] rd_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[int'(waddr)*PIX_W +: PIX_W] <= wdata;
    end
  end

  // NOTE: non-blocking updates let the read below sample the pre-write value,
  // which is exactly the read-first behaviour on an address collision.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_q <= '0;
    end else begin
      rd_q <= mem_q[int'(raddr)*PIX_W +: PIX_W];
    end
  end

  assign rdata = rd_q;

endmodule

// File: rtl/frame_buffer_ctrl.sv
// Frame buffer controller: external pixel writes, VGA read port and a
// whole-frame fill engine sharing one RAM write port.
module frame_buffer_ctrl
  import fb_pkg::*;
#(
  parameter int X_BITS       = 8,
  parameter int Y_BITS       = 7,
  parameter int PIX_W        = 1,
  parameter int INIT_PATTERN = INIT_CHECKER,
  parameter int GRID_BIT     = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [X_BITS-1:0] wr_x,
  input  logic [Y_BITS-1:0] wr_y,
  input  logic [PIX_W-1:0]  wr_data,
  input  logic              fill_start,
  input  logic [PIX_W-1:0]  fill_data,
  output logic              busy,
  output logic              fill_done,
  input  logic [X_BITS-1:0] rd_x,
  input  logic [Y_BITS-1:0] rd_y,
  output logic [PIX_W-1:0]  rd_data
);

  localparam int            AW        = X_BITS + Y_BITS;
  localparam logic [AW-1:0] LAST_ADDR = {AW{1'b1}};

  fb_state_t        state_q, state_d;
  logic [AW-1:0]    fill_cnt_q, fill_cnt_d;
  logic [PIX_W-1:0] fill_colour_q, fill_colour_d;
  logic             fill_done_q, fill_done_d;

  logic [AW-1:0]    wr_addr;
  logic [AW-1:0]    rd_addr;
  logic             ram_we;
  logic [AW-1:0]    ram_waddr;
  logic [PIX_W-1:0] ram_wdata;

  assign wr_addr = AW'(fb_addr(32'(wr_x), 32'(wr_y), X_BITS));
  assign rd_addr = AW'(fb_addr(32'(rd_x), 32'(rd_y), X_BITS));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      fill_cnt_q    <= '0;
      fill_colour_q <= '0;
      fill_done_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      fill_cnt_q    <= fill_cnt_d;
      fill_colour_q <= fill_colour_d;
      fill_done_q   <= fill_done_d;
    end
  end

  // NOTE: every output of this block is defaulted first so no path through the
  // case statement leaves a signal unassigned and infers a latch.
  always_comb begin
    state_d       = state_q;
    fill_cnt_d    = fill_cnt_q;
    fill_colour_d = fill_colour_q;
    fill_done_d   = 1'b0;
    ram_we        = 1'b0;
    ram_waddr     = wr_addr;
    ram_wdata     = wr_data;

    unique case (state_q)
      IDLE: begin
        ram_we = wr_valid;
        if (fill_start) begin
          state_d       = FILL;
          fill_cnt_d    = '0;
          fill_colour_d = fill_data;
        end
      end
      FILL: begin
        ram_we    = 1'b1;
        ram_waddr = fill_cnt_q;
        ram_wdata = fill_colour_q;
        if (fill_cnt_q == LAST_ADDR) begin
          state_d     = IDLE;
          fill_cnt_d  = '0;
          fill_done_d = 1'b1;
        end else begin
          fill_cnt_d = fill_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // A reset edge aborts the fill without committing the pending pixel.
    if (reset) begin
      ram_we = 1'b0;
    end
  end

  assign wr_ready  = (state_q == IDLE);
  assign busy      = (state_q == FILL);
  assign fill_done = fill_done_q;

  fb_ram #(
    .AW          (AW),
    .PIX_W       (PIX_W),
    .INIT_PATTERN(INIT_PATTERN),
    .GRID_BIT    (GRID_BIT),
    .X_BITS      (X_BITS)
  ) u_ram (
    .clk  (clk),
    .reset(reset),
    .we   (ram_we),
    .waddr(ram_waddr),
    .wdata(ram_wdata),
    .raddr(rd_addr),
    .rdata(rd_data)
  );

endmodule

// File: doc/frame_buffer_ctrl.md
# frame_buffer_ctrl

Parametrised single-clock frame buffer for the VGA path: a `2^X_BITS × 2^Y_BITS` array of `PIX_W`-bit pixels. It has a handshaked pixel-write port, a fixed-latency read port for the VGA signal generator, and a hardware fill engine that sweeps every address with a constant colour. It extends the 256×128 1-bit buffer with configurable geometry, multi-bit pixels, flow control and whole-frame clear.

## Interface
- `X_BITS`, 8, width of the X coordinate; frame width is `2^X_BITS`.
- `Y_BITS`, 7, width of the Y coordinate; frame height is `2^Y_BITS`.
- `PIX_W`, 1, bits per pixel.
- `INIT_PATTERN`, 1, power-up content: 0 = all zero; 1 = checkerboard where every bit of the pixel equals `x[GRID_BIT] ^ y[GRID_BIT]`.
- `GRID_BIT`, 0, coordinate bit used by the checkerboard.
- `clk` in 1: the only clock; all logic is on the rising edge.
- `reset` in 1: synchronous, active-high.
- `wr_valid` in 1: write request.
- `wr_ready` out 1: block can accept a write.
- `wr_x` in X_BITS, `wr_y` in Y_BITS: write coordinate.
- `wr_data` in PIX_W: write pixel.
- `fill_start` in 1: single-cycle request to fill the whole frame.
- `fill_data` in PIX_W: fill colour, sampled on the cycle `fill_start` is accepted.
- `busy` out 1: fill in progress.
- `fill_done` out 1: one-cycle pulse when a fill completes.
- `rd_x` in X_BITS, `rd_y` in Y_BITS: VGA read coordinate.
- `rd_data` out PIX_W: pixel at the read coordinate, registered.

## Operation
- **Addressing:** linear address = `{y, x}` (Y in the MSBs), `AW = X_BITS+Y_BITS`, `DEPTH = 2^AW`.
- **Memory init:** contents are initialised from `INIT_PATTERN` at configuration. `reset` never alters memory.
- **FSM states:** IDLE and FILL.
- **IDLE → FILL:** on `fill_start=1`. The block latches `fill_data` into `fill_colour` and clears `fill_cnt` to 0.
- **FILL:** each cycle writes `fill_colour` to address `fill_cnt`, then `fill_cnt++`.
  - When `fill_cnt == DEPTH-1`, that write is the last. Next state is IDLE and `fill_done` is set for one cycle.
- **`fill_start` in FILL:** ignored; no restart and no queueing.
- **Write handshake:** `wr_ready = (state == IDLE)`, combinational from registered state. A write commits on a cycle with `wr_valid && wr_ready`.
  - While busy, the requester holds `wr_valid`, `wr_x`, `wr_y` and `wr_data` stable.
- **`wr_valid` and `fill_start` in the same IDLE cycle:** the write commits that cycle. The fill starts next cycle and overwrites it.
- **Read port:** always active, including during FILL.
  - Read-during-write to the same address returns the OLD value (read-first).
- **Reset:** takes effect on the next edge and sets:
  - state = IDLE, `fill_cnt` = 0
  - `busy` = 0, `fill_done` = 0, `rd_data` = 0
- **Reset mid-fill:** the fill is aborted. Pixels already written stay written, and no `fill_done` pulse is produced.
- **Counter width:** `fill_cnt` is AW bits. The terminal compare is on `DEPTH-1`, so the counter never wraps while in FILL.

## Timing
- **Read latency:** `rd_x`/`rd_y` presented at edge t → `rd_data` valid after edge t+1, i.e. one cycle.
- **Write to visibility:** a write accepted at edge t is visible to a read address presented at edge t+1 or later.
- **Fill timing:** `fill_start` sampled at edge t → `busy`=1 from t+1 to t+DEPTH, exactly DEPTH cycles.
  - Fill writes occur at edges t+1 … t+DEPTH.
  - `busy`=0 and `fill_done`=1 during cycle t+DEPTH+1 only.
- **Back-to-back fills:** a new `fill_start` is accepted on the cycle `fill_done` is high.
- **Write throughput:** one write per cycle in IDLE.

## Structure
- **Package `fb_pkg`:**
  - state enum `fb_state_t` {IDLE, FILL}
  - `INIT_ZERO` / `INIT_CHECKER` constants
  - function `fb_addr(x, y)` returning `{y, x}`
- **Sub-module `fb_ram`:**
  - simple dual-port RAM with one write port and one registered read-first read port
  - parameters AW, PIX_W, INIT_PATTERN, GRID_BIT, X_BITS
  - holds the init loop
- **`frame_buffer_ctrl`:** FSM, fill counter and the write-port mux (fill writer vs external writer).

## Test plan
Parameters for all scenarios: `X_BITS=3`, `Y_BITS=2`, `PIX_W=4`, `INIT_PATTERN=1`, `GRID_BIT=0` (DEPTH=32).

1. **Init and read latency:** after reset, read (x=1,y=0) → `rd_data`=4'hF one cycle later; read (x=1,y=1) → 4'h0.
2. **Write then read:** write (x=5,y=2,data=4'hA) → reading (5,2) next cycle gives 4'hA. A same-cycle read of (5,2) during the write gives the old value 4'hF.
3. **Fill:** `fill_start` with `fill_data`=4'h3 → `busy` high exactly 32 cycles, `wr_ready` low throughout, `fill_done` a single pulse. Reads of all 32 addresses afterwards return 4'h3.
4. **Contention:** during a fill, `wr_valid` held with (0,0,4'h9) → not accepted until `wr_ready` rises, then (0,0) reads 4'h9. A second `fill_start` mid-fill → ignored, `busy` length still 32.
5. **Same-cycle write and fill:** `wr_valid`+`fill_start` in one IDLE cycle → write accepted, then the fill (4'h1) overwrites; all addresses read 4'h1.
6. **Reset mid-fill:** `reset` after 10 fill cycles → `busy`=0 and no `fill_done`. Addresses 0–9 hold the fill colour; addresses 10–31 keep their checkerboard values.
